// File: rtl/fib_seq_stream.sv
// Fibonacci accelerator kernel: single-result and streamed F(1)..F(n) modes,
// saturating signed arithmetic with a sticky per-job overflow flag, and the
// usual req/fin/ce kernel handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for req; fin pulse retires here
// LOOP  | single mode, advancing one term per counted edge until i==n
// EMIT  | stream mode, presenting b with valid, advancing on valid&ready
// DONE  | n<=0 job; clears the result, then raises fin
module fib_seq_stream #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 32
) (
  input  logic                      i_w_clk,
  input  logic                      i_w_res_n,
  input  logic                      i_w_ce_p,
  input  logic                      i_w_req_p,
  input  logic                      i_w_stream_p,
  input  logic signed [N_WIDTH-1:0] i_w_n,
  input  logic                      i_w_ready_p,
  output logic signed [WIDTH-1:0]   o_r_o,
  output logic                      o_r_valid_p,
  output logic                      o_r_ovf_p,
  output logic                      o_r_busy_p,
  output logic                      o_r_fin_p
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOP,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0]          MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]          ONE_W   = WIDTH'(1);
  localparam logic signed [N_WIDTH-1:0] ZERO_N  = '0;
  localparam logic signed [N_WIDTH-1:0] ONE_N   = N_WIDTH'(1);

  state_t                      state_r;
  logic [WIDTH-1:0]            a_r;
  logic [WIDTH-1:0]            b_r;
  logic signed [N_WIDTH-1:0]   i_r;
  logic signed [N_WIDTH-1:0]   n_r;

  logic [WIDTH:0]              sum_w;
  logic                        sat_w;
  logic [WIDTH-1:0]            a_next;
  logic [WIDTH-1:0]            b_next;

  // Next term pair; a and b are never negative, so the sum is taken unsigned
  // one bit wider and compared against the positive signed limit. Once the
  // job has overflowed both terms are pinned at the limit.
  always_comb begin
    sum_w  = {1'b0, a_r} + {1'b0, b_r};
    sat_w  = o_r_ovf_p || (sum_w > {1'b0, MAX_POS});
    a_next = o_r_ovf_p ? MAX_POS : b_r;
    b_next = sat_w ? MAX_POS : sum_w[WIDTH-1:0];
  end

  // Controller: every register, including the outputs, advances only on a
  // counted edge. The empty-job path spends two counted edges in DONE, using
  // the idle index register as its step marker.
  always_ff @(posedge i_w_clk or negedge i_w_res_n) begin
    if (!i_w_res_n) begin
      state_r     <= S_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      i_r         <= '0;
      n_r         <= '0;
      o_r_o       <= '0;
      o_r_valid_p <= 1'b0;
      o_r_ovf_p   <= 1'b0;
      o_r_busy_p  <= 1'b0;
      o_r_fin_p   <= 1'b0;
    end else if (i_w_ce_p) begin
      o_r_fin_p <= 1'b0;
      case (state_r)
        S_IDLE: begin
          o_r_valid_p <= 1'b0;
          if (i_w_req_p) begin
            n_r        <= i_w_n;
            o_r_ovf_p  <= 1'b0;
            a_r        <= '0;
            b_r        <= ONE_W;
            i_r        <= ONE_N;
            o_r_busy_p <= 1'b1;
            if (i_w_n <= ZERO_N) begin
              state_r <= S_DONE;
            end else if (i_w_stream_p) begin
              state_r     <= S_EMIT;
              o_r_valid_p <= 1'b1;
              o_r_o       <= ONE_W;
            end else begin
              state_r <= S_LOOP;
            end
          end
        end

        S_LOOP: begin
          if (i_r < n_r) begin
            a_r       <= a_next;
            b_r       <= b_next;
            i_r       <= i_r + ONE_N;
            o_r_ovf_p <= sat_w;
          end else begin
            o_r_o      <= b_r;
            o_r_fin_p  <= 1'b1;
            o_r_busy_p <= 1'b0;
            state_r    <= S_IDLE;
          end
        end

        S_EMIT: begin
          if (i_w_ready_p) begin
            if (i_r == n_r) begin
              o_r_valid_p <= 1'b0;
              o_r_fin_p   <= 1'b1;
              o_r_busy_p  <= 1'b0;
              state_r     <= S_IDLE;
            end else begin
              a_r       <= a_next;
              b_r       <= b_next;
              i_r       <= i_r + ONE_N;
              o_r_ovf_p <= sat_w;
              o_r_o     <= b_next;
            end
          end
        end

        S_DONE: begin
          if (i_r != ZERO_N) begin
            i_r   <= ZERO_N;
            o_r_o <= '0;
          end else begin
            o_r_fin_p  <= 1'b1;
            o_r_busy_p <= 1'b0;
            state_r    <= S_IDLE;
          end
        end

        default: begin
          state_r     <= S_IDLE;
          o_r_valid_p <= 1'b0;
          o_r_busy_p  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_seq_stream.sv
// Scoreboard bench for fib_seq_stream: expected terms and completions are
// queued at request time from a Fibonacci table; a monitor pops on every
// handshake and fin pulse.
module tb_fib_seq_stream;

  localparam int    W    = 16;
  localparam int    NW   = 16;
  localparam longint MAXV = 32767;

  logic                  i_w_clk;
  logic                  i_w_res_n;
  logic                  i_w_ce_p;
  logic                  i_w_req_p;
  logic                  i_w_stream_p;
  logic signed [NW-1:0]  i_w_n;
  logic                  i_w_ready_p;
  logic signed [W-1:0]   o_r_o;
  logic                  o_r_valid_p;
  logic                  o_r_ovf_p;
  logic                  o_r_busy_p;
  logic                  o_r_fin_p;

  fib_seq_stream #(.WIDTH(W), .N_WIDTH(NW)) dut (
    .i_w_clk      (i_w_clk),
    .i_w_res_n    (i_w_res_n),
    .i_w_ce_p     (i_w_ce_p),
    .i_w_req_p    (i_w_req_p),
    .i_w_stream_p (i_w_stream_p),
    .i_w_n        (i_w_n),
    .i_w_ready_p  (i_w_ready_p),
    .o_r_o        (o_r_o),
    .o_r_valid_p  (o_r_valid_p),
    .o_r_ovf_p    (o_r_ovf_p),
    .o_r_busy_p   (o_r_busy_p),
    .o_r_fin_p    (o_r_fin_p)
  );

  initial i_w_clk = 1'b0;
  always #5 i_w_clk = ~i_w_clk;

  typedef struct {
    bit     is_fin;
    longint val;
    bit     chk_val;
    bit     ovf;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad   = 0;
  longint fib_tab[0:40];
  bit     pat[8] = '{1, 0, 0, 1, 1, 0, 1, 1};

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sat_fib(input int k);
    return (fib_tab[k] > MAXV) ? MAXV : fib_tab[k];
  endfunction

  // monitor: pops one expectation per handshake and per fin rising edge
  logic   fin_q = 1'b0;
  bit     hold_chk = 1'b0;
  longint held = 0;
  always @(negedge i_w_clk) begin
    exp_t e;
    if (!i_w_res_n) begin
      fin_q    = 1'b0;
      hold_chk = 1'b0;
    end else begin
      if (o_r_valid_p) begin
        if (hold_chk) check("stream_hold", longint'(o_r_o), held);
        if (i_w_ready_p && i_w_ce_p) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL term_unexpected: got %0d expected none", o_r_o);
          end else begin
            e = sb.pop_front();
            if (e.is_fin) begin
              bad++;
              $display("FAIL term_order: got term %0d expected fin", o_r_o);
            end else if (longint'(o_r_o) !== e.val) begin
              bad++;
              $display("FAIL term_value: got %0d expected %0d", o_r_o, e.val);
            end
          end
          hold_chk = 1'b0;
        end else begin
          held     = longint'(o_r_o);
          hold_chk = 1'b1;
        end
      end else begin
        hold_chk = 1'b0;
      end
      if (o_r_fin_p && !fin_q) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL fin_unexpected: got fin expected none");
        end else begin
          e = sb.pop_front();
          check("fin_kind", longint'(e.is_fin), 1);
          check("fin_ovf", longint'(o_r_ovf_p), longint'(e.ovf));
          if (e.chk_val) check("fin_value", longint'(o_r_o), e.val);
        end
      end
      fin_q = o_r_fin_p;
    end
  end

  task automatic tick();
    @(posedge i_w_clk);
    #1;
  endtask

  task automatic push_job(input int n, input bit stream);
    exp_t e;
    if (n <= 0) begin
      e = '{is_fin: 1'b1, val: 0, chk_val: 1'b1, ovf: 1'b0};
      sb.push_back(e);
    end else if (stream) begin
      for (int k = 1; k <= n; k++) begin
        e = '{is_fin: 1'b0, val: sat_fib(k), chk_val: 1'b0, ovf: 1'b0};
        sb.push_back(e);
      end
      e = '{is_fin: 1'b1, val: 0, chk_val: 1'b0, ovf: (fib_tab[n] > MAXV)};
      sb.push_back(e);
    end else begin
      e = '{is_fin: 1'b1, val: sat_fib(n), chk_val: 1'b1, ovf: (fib_tab[n] > MAXV)};
      sb.push_back(e);
    end
  endtask

  task automatic issue_req(input int n, input bit stream);
    push_job(n, stream);
    i_w_ce_p     = 1'b1;
    i_w_req_p    = 1'b1;
    i_w_stream_p = stream;
    i_w_n        = NW'(n);
    tick();
    i_w_req_p    = 1'b0;
  endtask

  // ce_mode: 0 always on, 1 random, 2 low for loop cycles 4..8 with req pulses
  // rdy_mode: 0 fixed pattern, 1 random, 2 always ready
  task automatic run_job(input int n, input bit stream, input int ce_mode,
                         input int rdy_mode, input int exp_lat, input int exp_edges);
    int  counted = 0;
    int  edges   = 0;
    bit  saw_valid = 1'b0;
    bit  done = 1'b0;
    issue_req(n, stream);
    if (o_r_valid_p) saw_valid = 1'b1;
    for (int j = 0; j < 600 && !done; j++) begin
      case (ce_mode)
        0: i_w_ce_p = 1'b1;
        1: i_w_ce_p = ($urandom_range(3, 0) != 0);
        default: i_w_ce_p = !(j >= 4 && j <= 8);
      endcase
      case (rdy_mode)
        0: i_w_ready_p = pat[j % 8];
        1: i_w_ready_p = ($urandom_range(2, 0) != 0);
        default: i_w_ready_p = 1'b1;
      endcase
      if (ce_mode == 2) i_w_req_p = (j == 2 || j == 6);
      else if (ce_mode == 1) i_w_req_p = ($urandom_range(7, 0) == 0);
      i_w_stream_p = $urandom_range(1, 0);
      i_w_n        = NW'($urandom_range(9, 1));
      if (i_w_ce_p) counted++;
      edges++;
      tick();
      if (o_r_valid_p) saw_valid = 1'b1;
      if (o_r_fin_p) done = 1'b1;
    end
    i_w_req_p = 1'b0;
    i_w_ce_p  = 1'b1;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL job_timeout: got no fin expected fin for n=%0d", n);
    end
    if (exp_lat >= 0) check("latency", counted, exp_lat);
    if (exp_edges >= 0) check("elapsed_edges", edges, exp_edges);
    if (!stream || n <= 0) check("no_valid", longint'(saw_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fib_tab[0] = 0;
    fib_tab[1] = 1;
    for (int k = 2; k <= 40; k++) fib_tab[k] = fib_tab[k-1] + fib_tab[k-2];

    i_w_res_n    = 1'b0;
    i_w_ce_p     = 1'b0;
    i_w_req_p    = 1'b0;
    i_w_stream_p = 1'b0;
    i_w_n        = '0;
    i_w_ready_p  = 1'b0;
    repeat (3) tick();
    check("rst_o", longint'(o_r_o), 0);
    check("rst_valid", longint'(o_r_valid_p), 0);
    check("rst_ovf", longint'(o_r_ovf_p), 0);
    check("rst_busy", longint'(o_r_busy_p), 0);
    check("rst_fin", longint'(o_r_fin_p), 0);
    i_w_res_n = 1'b1;
    i_w_ce_p  = 1'b1;
    tick();

    // single n=10, then verify fin lasts one cycle
    run_job(10, 1'b0, 0, 2, 10, 10);
    check("busy_after_fin", longint'(o_r_busy_p), 0);
    tick();
    check("fin_pulse", longint'(o_r_fin_p), 0);

    // empty jobs in both modes
    run_job(0, 1'b0, 0, 2, 2, 2);
    run_job(-5, 1'b0, 0, 2, 2, 2);
    run_job(0, 1'b1, 0, 2, 2, 2);
    run_job(-5, 1'b1, 0, 2, 2, 2);

    // stream n=6 with the 1,0,0,1,1,0,1,1 ready pattern
    run_job(6, 1'b1, 0, 0, 9, 9);

    // n=1 single: fin one edge after req, back-to-back with previous fin
    run_job(1, 1'b0, 0, 2, 1, 1);

    // overflow then clean job
    run_job(24, 1'b0, 0, 2, 24, 24);
    run_job(23, 1'b0, 0, 2, 23, 23);
    run_job(25, 1'b1, 0, 2, -1, -1);

    // ce gap of 5 cycles with reqs while busy
    run_job(20, 1'b0, 2, 2, 20, 25);

    // reset mid-stream while term 3 is presented
    issue_req(6, 1'b1);
    i_w_ready_p = 1'b1;
    tick();
    tick();
    i_w_ready_p = 1'b0;
    check("pre_rst_term3", longint'(o_r_o), 2);
    i_w_res_n = 1'b0;
    #1;
    check("mid_rst_o", longint'(o_r_o), 0);
    check("mid_rst_valid", longint'(o_r_valid_p), 0);
    check("mid_rst_busy", longint'(o_r_busy_p), 0);
    check("mid_rst_fin", longint'(o_r_fin_p), 0);
    sb.delete();
    repeat (2) tick();
    i_w_res_n = 1'b1;
    begin
      bit seen = 1'b0;
      for (int j = 0; j < 4; j++) begin
        tick();
        if (o_r_fin_p || o_r_valid_p) seen = 1'b1;
      end
      check("post_rst_quiet", longint'(seen), 0);
    end
    run_job(3, 1'b1, 0, 2, 3, 3);

    // randomized jobs
    for (int t = 0; t < 40; t++) begin
      int  n;
      bit  s;
      n = int'($urandom_range(29, 0)) - 3;
      s = $urandom_range(1, 0);
      if (n <= 0) run_job(n, s, 1, 1, 2, -1);
      else if (!s) run_job(n, s, 1, 1, n, -1);
      else run_job(n, s, 1, 1, -1, -1);
    end

    repeat (4) tick();
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
